// File: rtl/bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
// It takes an unsigned operand and produces four BCD digits for the four-digit
// seven-segment display. The digits are held stable between conversions, so
// the display never shows intermediate accumulator values. Operands above 9999
// saturate the display to 9999 and raise ovf.
//
// Ports
//   clk    : system clock, rising edge
//   clr    : asynchronous active-low reset
//   start  : conversion request, sampled only when idle
//   bin    : unsigned operand [BIN_W-1:0], sampled on the accepting edge
//   busy   : high while a conversion is in progress (BIN_W+1 cycles)
//   done   : one-cycle pulse when new digits are valid
//   ovf    : last converted operand was greater than 9999
//   dig1   : thousands digit (leftmost)
//   dig2   : hundreds digit
//   dig3   : tens digit
//   dig4   : ones digit (rightmost)
// -----------------------------------------------------------------------------
module bin_to_bcd_converter #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic [3:0]       dig4
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(BIN_W);

    state_t           state_r, state_s;
    logic [BIN_W-1:0] opnd_r, opnd_s;
    logic [15:0]      acc_r, acc_s;
    logic [15:0]      acc_adj_s;
    logic [3:0]       cnt_r, cnt_s;
    logic             pend_ovf_r, pend_ovf_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             ovf_r, ovf_s;
    logic [15:0]      digs_r, digs_s;

    // Add 3 to every BCD nibble that is 5 or more, all nibbles in parallel.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 4; i++) begin
            if (a[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = a[i*4 +: 4];
            end
        end
        return r;
    endfunction

    assign acc_adj_s = dabble_adjust(acc_r);

    // Next-state logic of the conversion sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                // Leave SHIFT on the edge where the counter runs 1 -> 0.
                if (cnt_r == 4'd1) begin
                    state_s = COMMIT;
                end else begin
                    state_s = SHIFT;
                end
            end
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        opnd_s     = opnd_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        pend_ovf_s = pend_ovf_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        ovf_s      = ovf_r;
        digs_s     = digs_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    opnd_s     = bin;
                    acc_s      = 16'd0;
                    cnt_s      = CNT_INIT;
                    pend_ovf_s = (32'(bin) > 32'd9999);
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = busy_r;
                end
            end
            SHIFT: begin
                // Adjusted accumulator and operand shift left as one register;
                // the fifth-digit carry falls off the top.
                {acc_s, opnd_s} = {acc_adj_s, opnd_r} << 1;
                cnt_s           = cnt_r - 4'd1;
            end
            COMMIT: begin
                if (pend_ovf_r) begin
                    digs_s = 16'h9999;
                end else begin
                    digs_s = acc_r;
                end
                ovf_s  = pend_ovf_r;
                done_s = 1'b1;
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; a reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            opnd_r     <= '0;
            acc_r      <= 16'd0;
            cnt_r      <= 4'd0;
            pend_ovf_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            digs_r     <= 16'd0;
        end else begin
            opnd_r     <= opnd_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
            pend_ovf_r <= pend_ovf_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            ovf_r      <= ovf_s;
            digs_r     <= digs_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign ovf  = ovf_r;
    assign dig1 = digs_r[15:12];
    assign dig2 = digs_r[11:8];
    assign dig3 = digs_r[7:4];
    assign dig4 = digs_r[3:0];

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_converter
//
// Scoreboard bench for bin_to_bcd_converter (BIN_W = 14). The stimulus process
// pushes the expected result and its due cycle into a queue on every accepted
// start; a monitor process checks busy, done and the held digits every cycle
// and pops/compares the queue head when its done cycle arrives.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_converter;

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;

    logic             clk;
    logic             clr;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       dig1;
    logic [3:0]       dig2;
    logic [3:0]       dig3;
    logic [3:0]       dig4;

    typedef struct {
        int          due;
        logic [16:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc      = 0;
    int          busy_end = 0;
    logic [16:0] held     = 17'd0;
    int          n_chk    = 0;
    int          n_pass   = 0;

    bin_to_bcd_converter #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dig1  (dig1),
        .dig2  (dig2),
        .dig3  (dig3),
        .dig4  (dig4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by plain arithmetic, saturating above 9999.
    function automatic logic [16:0] ref_model(input int v);
        logic [16:0] r;
        if (v > 9999) begin
            r = {1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
        end else begin
            r = {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Raise start with operand v for exactly the accepting edge.
    task automatic issue(input int v);
        exp_t e;
        bin   = v[BIN_W-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        e.due    = cyc + LAT;
        e.val    = ref_model(v);
        busy_end = cyc + LAT;
        exp_q.push_back(e);
        start = 1'b0;
    endtask

    // Issue a conversion and return in its done cycle.
    task automatic run(input int v);
        issue(v);
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (clr) begin
                chk("busy", 32'(busy), 32'(cyc < busy_end));
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    chk("done_pulse", 32'(done), 32'd1);
                    chk("result", 32'({ovf, dig1, dig2, dig3, dig4}), 32'(exp_q[0].val));
                    held = exp_q[0].val;
                    void'(exp_q.pop_front());
                end else begin
                    chk("done_idle", 32'(done), 32'd0);
                    chk("hold", 32'({ovf, dig1, dig2, dig3, dig4}), 32'(held));
                end
            end
        end
    end

    initial begin
        clr   = 1'b0;
        start = 1'b0;
        bin   = '0;
        #12;
        chk("reset_state", 32'({busy, done, ovf, dig1, dig2, dig3, dig4}), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed values, including both saturation cases and recovery.
        run(1234);
        run(0);
        run(9999);
        run(10000);
        run(16383);
        run(42);
        repeat (2) @(posedge clk);
        #1;

        // A second start while busy is ignored.
        issue(5678);
        repeat (4) @(posedge clk);
        #1;
        bin   = 14'd1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (LAT - 5) @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back: start raised during the done cycle is accepted at once.
        run(1357);
        run(2468);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of SHIFT.
        run(1234);
        issue(9876);
        repeat (6) @(posedge clk);
        #3;
        clr = 1'b0;
        exp_q.delete();
        busy_end = 0;
        held     = 17'd0;
        #1;
        chk("async_clear", 32'({busy, done, ovf, dig1, dig2, dig3, dig4}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        run(777);

        // Randomized operands with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            run(int'($urandom_range(0, 16383)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
